// File: rtl/iq_adc_sequencer_if.sv
// Bus bundle between the I/Q ADC sequencer, the shared ADC and the differentiator.
// master = sequencer side, slave = ADC/differentiator side.
`timescale 1ns/1ps
interface iq_adc_sequencer_if;
    logic [2:0] adc_ch;
    logic       adc_start;
    logic       adc_done;
    logic [9:0] adc_data;
    logic       diff_en;
    logic [2:0] diff_channel;
    logic [9:0] diff_x;
    logic       pair_tick;

    modport master (
        output adc_ch, adc_start, diff_en, diff_channel, diff_x, pair_tick,
        input  adc_done, adc_data
    );

    modport slave (
        input  adc_ch, adc_start, diff_en, diff_channel, diff_x, pair_tick,
        output adc_done, adc_data
    );
endinterface

// File: rtl/iq_adc_sequencer.sv
// Time-shares one ADC between the FM demodulator I and Q inputs, one I/Q pair per period.
// Optional macro ADC_TIMEOUT_EN adds a WAIT watchdog that publishes midscale on a dead ADC.
`timescale 1ns/1ps
module iq_adc_sequencer #(
    parameter logic [2:0] I_CH    = 3'b110,
    parameter logic [2:0] Q_CH    = 3'b100,
    parameter int         SETTLE  = 4,
    parameter int         PERIOD  = 64,
    parameter int         TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    iq_adc_sequencer_if.master bus,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err
);
    localparam int CW = (PERIOD < 2) ? 1 : $clog2(PERIOD);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_PUBLISH
    } state_t;

    // Zero settle time skips straight from the mux change to the conversion start.
    localparam state_t ST_AFTER_MUX = (SETTLE == 0) ? ST_START : ST_SETTLE;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [2:0]    adc_ch_q, adc_ch_d;
    logic [2:0]    diff_channel_q, diff_channel_d;
    logic [9:0]    diff_x_q, diff_x_d;
    logic          overrun_q, overrun_d;
    logic          run_q;
    logic          boundary;
    logic          run_rise;

`ifdef ADC_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    assign boundary = run && (cnt_q == '0);
    assign run_rise = run && !run_q;

    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        settle_d       = settle_q;
        adc_ch_d       = adc_ch_q;
        diff_channel_d = diff_channel_q;
        diff_x_d       = diff_x_q;
        overrun_d      = overrun_q;
`ifdef ADC_TIMEOUT_EN
        wait_d         = wait_q;
        timeout_err_d  = timeout_err_q;
        if (run_rise) begin
            timeout_err_d = 1'b0;
        end
`endif
        // A fresh run clears the sticky flags, but an event in the same cycle still sets them.
        if (run_rise) begin
            overrun_d = 1'b0;
        end
        if (boundary && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (boundary) begin
                    phase_d  = 1'b0;
                    adc_ch_d = I_CH;
                    settle_d = SETTLE_LD;
                    state_d  = ST_AFTER_MUX;
                end
            end
            ST_SETTLE: begin
                if (settle_q <= SW'(1)) begin
                    state_d = ST_START;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_START: begin
`ifdef ADC_TIMEOUT_EN
                wait_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.adc_done) begin
                    diff_x_d       = bus.adc_data;
                    diff_channel_d = phase_q ? Q_CH : I_CH;
                    state_d        = ST_PUBLISH;
                end
`ifdef ADC_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    diff_x_d       = 10'd512;
                    diff_channel_d = phase_q ? Q_CH : I_CH;
                    timeout_err_d  = 1'b1;
                    state_d        = ST_PUBLISH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            ST_PUBLISH: begin
                if (!phase_q) begin
                    phase_d  = 1'b1;
                    adc_ch_d = Q_CH;
                    settle_d = SETTLE_LD;
                    state_d  = ST_AFTER_MUX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= 1'b0;
            cnt_q          <= '0;
            settle_q       <= '0;
            adc_ch_q       <= I_CH;
            diff_channel_q <= 3'b000;
            diff_x_q       <= 10'd0;
            overrun_q      <= 1'b0;
            run_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            settle_q       <= settle_d;
            adc_ch_q       <= adc_ch_d;
            diff_channel_q <= diff_channel_d;
            diff_x_q       <= diff_x_d;
            overrun_q      <= overrun_d;
            run_q          <= run;
        end
    end

`ifdef ADC_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // Without the watchdog the flag never sets; the compare folds to 0 for any legal TIMEOUT.
    assign timeout_err = (TIMEOUT < 0);
`endif

    assign bus.adc_ch       = adc_ch_q;
    assign bus.adc_start    = (state_q == ST_START);
    assign bus.diff_en      = (state_q == ST_PUBLISH);
    assign bus.diff_channel = diff_channel_q;
    assign bus.diff_x       = diff_x_q;
    assign bus.pair_tick    = (state_q == ST_PUBLISH) && phase_q;
    assign busy             = (state_q != ST_IDLE);
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_iq_adc_sequencer.sv
// Randomized bench for iq_adc_sequencer: a pair-level timeline model predicts every output
// each cycle; build with ADC_TIMEOUT_EN defined to cover the watchdog.
`timescale 1ns/1ps
module tb_iq_adc_sequencer;
    localparam int         SETTLE  = 4;
    localparam int         PERIOD  = 32;
    localparam int         TIMEOUT = 20;
    localparam logic [2:0] I_CH    = 3'b110;
    localparam logic [2:0] Q_CH    = 3'b100;
    localparam int         NCYC    = 5000;
    localparam int         RUN_AT  = 100;
`ifdef ADC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic busy, overrun, timeout_err;

    iq_adc_sequencer_if bus();

    iq_adc_sequencer #(
        .I_CH(I_CH), .Q_CH(Q_CH), .SETTLE(SETTLE), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .bus(bus),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // expected outputs for the current cycle
    bit         chk_valid = 1'b0;
    logic [2:0] e_adc_ch, e_dch;
    logic [9:0] e_dx;
    logic       e_start, e_den, e_tick, e_busy, e_ovr, e_terr;

    // pair timeline: boundary, I start/publish, Q start/publish (absolute cycles)
    bit         pact = 1'b0;
    int         pb, psi, ppi, psq, ppq;
    bit         ptoi, ptoq;
    logic [9:0] pxi, pxq;
    int         pair_n = 0;

    logic [2:0] h_adc_ch = I_CH;
    logic [2:0] h_dch    = 3'b000;
    logic [9:0] h_dx     = 10'd0;
    bit         m_ovr = 1'b0, m_terr = 1'b0;
    bit         run_prev = 1'b0;
    int         run_k = 0, low_left = 0, rise_cyc = -1;
    bit         drop_done = 1'b0, mr_done = 1'b0;

    // DUT-observed strobe log
    int         start_cnt = 0, den_cnt = 0, last_start = 0, ev_n = 0;
    int         ev_cyc[16];
    int         ev_gap[16];
    logic [2:0] ev_ch[16];
    logic [9:0] ev_x[16];
    logic       ev_tick[16];
    logic       ev_terr[16];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One phase: WAIT opens the cycle after start; done after l cycles, or the watchdog fires.
    task automatic phase_times(input int s, input int l, output int p, output bit to);
        if (TO_EN && l >= TIMEOUT) begin
            p  = s + 1 + TIMEOUT;
            to = 1'b1;
        end else begin
            p  = s + 1 + l + 1;
            to = 1'b0;
        end
    endtask

    task automatic plan_pair(input int b, input int li, input int lq,
                             input logic [9:0] xi, input logic [9:0] xq);
        pact = 1'b1;
        pb   = b;
        psi  = b + 1 + SETTLE;
        phase_times(psi, li, ppi, ptoi);
        psq  = ppi + 1 + SETTLE;
        phase_times(psq, lq, ppq, ptoq);
        pxi  = ptoi ? 10'd512 : xi;
        pxq  = ptoq ? 10'd512 : xq;
        pair_n++;
    endtask

    task automatic model_reset();
        pact     = 1'b0;
        h_adc_ch = I_CH;
        h_dch    = 3'b000;
        h_dx     = 10'd0;
        m_ovr    = 1'b0;
        m_terr   = 1'b0;
        run_prev = 1'b0;
        run_k    = 0;
        low_left = 0;
    endtask

    task automatic mid_reset();
        chk_valid     = 1'b0;
        run           = 1'b0;
        bus.adc_done  = 1'b0;
        rst           = 1'b1;
        #1;
        cmp("rst_adc_ch", bus.adc_ch, I_CH);
        cmp("rst_start", bus.adc_start, 0);
        cmp("rst_diff_en", bus.diff_en, 0);
        cmp("rst_diff_x", bus.diff_x, 0);
        cmp("rst_diff_ch", bus.diff_channel, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_overrun", overrun, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_reset();
    endtask

    // single compare process: model expectations against the DUT on every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (chk_valid) begin
                cmp("adc_ch", bus.adc_ch, e_adc_ch);
                cmp("adc_start", bus.adc_start, e_start);
                cmp("diff_en", bus.diff_en, e_den);
                cmp("diff_channel", bus.diff_channel, e_dch);
                cmp("diff_x", bus.diff_x, e_dx);
                cmp("pair_tick", bus.pair_tick, e_tick);
                cmp("busy", busy, e_busy);
                cmp("overrun", overrun, e_ovr);
                cmp("timeout_err", timeout_err, e_terr);
                if (bus.adc_start === 1'b1) begin
                    start_cnt++;
                    last_start = cyc;
                end
                if (bus.diff_en === 1'b1) begin
                    den_cnt++;
                    if (ev_n < 16) begin
                        ev_cyc[ev_n]  = cyc;
                        ev_gap[ev_n]  = cyc - last_start;
                        ev_ch[ev_n]   = bus.diff_channel;
                        ev_x[ev_n]    = bus.diff_x;
                        ev_tick[ev_n] = bus.pair_tick;
                        ev_terr[ev_n] = timeout_err;
                    end
                    ev_n++;
                end
            end
        end
    end

    initial begin
        bit         run_v, bnd, busy_now, ovr_set, done_v;
        logic [9:0] data_v;
        int         li, lq;

        bus.adc_done = 1'b0;
        bus.adc_data = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int it = 0; it < NCYC; it++) begin
            if (it > 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!mr_done && cyc >= 3500 && pact && cyc > psi && cyc < ppi) begin
                mid_reset();
                mr_done = 1'b1;
            end
            if (cyc == RUN_AT) begin
                cmp("idle_starts", start_cnt, 0);
                cmp("idle_strobes", den_cnt, 0);
                cmp("idle_adc_ch", bus.adc_ch, 3'b110);
            end

            // expected outputs of this cycle from the pair timeline
            if (pact && cyc == pb + 1)  h_adc_ch = I_CH;
            if (pact && cyc == ppi + 1) h_adc_ch = Q_CH;
            if (pact && cyc == ppi) begin h_dch = I_CH; h_dx = pxi; end
            if (pact && cyc == ppq) begin h_dch = Q_CH; h_dx = pxq; end
            busy_now  = pact && cyc > pb && cyc <= ppq;
            e_adc_ch  = h_adc_ch;
            e_dch     = h_dch;
            e_dx      = h_dx;
            e_start   = pact && (cyc == psi || cyc == psq);
            e_den     = pact && (cyc == ppi || cyc == ppq);
            e_tick    = pact && cyc == ppq;
            e_busy    = busy_now;
            e_ovr     = m_ovr;
            e_terr    = m_terr;
            chk_valid = 1'b1;

            // run schedule: one drop right after an I strobe, then occasional random drops
            if (cyc >= RUN_AT && low_left == 0) begin
                if (!drop_done && pair_n == 7 && pact && cyc == ppi + 1) begin
                    low_left  = $urandom_range(80, 120);
                    drop_done = 1'b1;
                end else if (pair_n > 7 && $urandom_range(0, 299) == 0) begin
                    low_left = $urandom_range(80, 120);
                end
            end
            if (low_left > 0) begin
                run_v = 1'b0;
                low_left--;
            end else begin
                run_v = (cyc >= RUN_AT);
            end

            bnd     = run_v && (run_k % PERIOD == 0);
            ovr_set = bnd && busy_now;
            if (bnd && !busy_now) begin
                if (pair_n < 2) begin
                    plan_pair(cyc, 2, 2, 10'h2A0, 10'h120);
                end else if (pair_n == 2 && TO_EN) begin
                    plan_pair(cyc, 999, 999, 10'd0, 10'd0);
                end else begin
                    li = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 9);
                    lq = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 9);
                    plan_pair(cyc, li, lq, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
                end
            end

            // ADC: the planned done inside WAIT, spurious dones anywhere outside WAIT
            done_v = 1'b0;
            data_v = 10'($urandom_range(0, 1023));
            if (pact && !ptoi && cyc == ppi - 1) begin
                done_v = 1'b1;
                data_v = pxi;
            end else if (pact && !ptoq && cyc == ppq - 1) begin
                done_v = 1'b1;
                data_v = pxq;
            end else if (!(pact && ((cyc > psi && cyc < ppi) || (cyc > psq && cyc < ppq)))) begin
                done_v = ($urandom_range(0, 3) == 0);
            end

            // sticky flags as seen next cycle
            if (run_v && !run_prev) begin
                m_ovr  = 1'b0;
                m_terr = 1'b0;
                if (rise_cyc < 0) rise_cyc = cyc;
            end
            if (ovr_set) m_ovr = 1'b1;
            if (pact && ((ptoi && cyc == ppi - 1) || (ptoq && cyc == ppq - 1))) m_terr = 1'b1;
            run_k    = run_v ? run_k + 1 : 0;
            run_prev = run_v;

            run          = run_v;
            bus.adc_done = done_v;
            bus.adc_data = data_v;
        end

        @(negedge clk);
        chk_valid = 1'b0;

        // hand-computed pins for the first pairs: boundary at the run rise, settle 4, done 3 after start
        cmp("mid_reset_hit", mr_done, 1);
        cmp("strobe_count_min", ev_n >= 6, 1);
        if (ev_n >= 6) begin
            cmp("p0_i_when", ev_cyc[0] - rise_cyc, 9);
            cmp("p0_i_ch", ev_ch[0], 3'b110);
            cmp("p0_i_x", ev_x[0], 10'h2A0);
            cmp("p0_i_gap", ev_gap[0], 4);
            cmp("p0_i_tick", ev_tick[0], 0);
            cmp("p0_q_when", ev_cyc[1] - rise_cyc, 18);
            cmp("p0_q_ch", ev_ch[1], 3'b100);
            cmp("p0_q_x", ev_x[1], 10'h120);
            cmp("p0_q_tick", ev_tick[1], 1);
            cmp("p1_i_when", ev_cyc[2] - rise_cyc, 41);
            cmp("p1_q_x", ev_x[3], 10'h120);
`ifdef ADC_TIMEOUT_EN
            cmp("to_i_gap", ev_gap[4], 21);
            cmp("to_i_x", ev_x[4], 10'd512);
            cmp("to_i_flag", ev_terr[4], 1);
            cmp("to_q_gap", ev_gap[5], 21);
            cmp("to_q_ch", ev_ch[5], 3'b100);
            cmp("to_q_x", ev_x[5], 10'd512);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iq_adc_sequencer.md
Name: iq_adc_sequencer

Overview:
- Schedules the single shared ADC between the I (channel 3'b110) and Q (channel 3'b100) inputs of the FM demodulator.
- Per sample period: selects the mux channel, waits settling, triggers a conversion and captures the result. It then presents each sample to the differentiator as an (en, channel, X) strobe.
- Emits one pair tick per completed I/Q pair, which paces the downstream FIR.

Parameters:
- I_CH, 3'b110, ADC mux code for I
- Q_CH, 3'b100, ADC mux code for Q
- SETTLE, 4, clk cycles between mux change and conversion start (0 allowed)
- PERIOD, 64, clk cycles per I/Q pair (must be >= 4)
- TIMEOUT, 255, max clk cycles waiting for adc_done (ADC_TIMEOUT_EN only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  enable sampling
- adc_ch  out  3  ADC mux select
- adc_start  out  1  1-cycle conversion start pulse
- adc_done  in  1  1-cycle conversion complete strobe
- adc_data  in  10  unsigned offset-binary ADC result, valid with adc_done
- diff_en  out  1  1-cycle sample strobe to differentiator
- diff_channel  out  3  I_CH or Q_CH, valid with diff_en
- diff_x  out  10  captured sample, valid with diff_en
- pair_tick  out  1  1-cycle pulse, coincident with the Q diff_en
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: period boundary hit while busy
- timeout_err  out  1  sticky ADC timeout flag (feature)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (all outputs): every output is 0, except adc_ch = I_CH. Period counter = 0, FSM in IDLE, phase = I.
- Period counter:
  - Counts 0..PERIOD-1 and wraps while run=1.
  - Held at 0 while run=0.
  - Boundary = counter==0 with run=1.
- FSM states: IDLE, SETTLE, START, WAIT, PUBLISH. A phase bit selects I or Q.
  - IDLE: on boundary, set phase=I, adc_ch<=I_CH, load settle count, go to SETTLE. If SETTLE=0, go directly to START.
  - Boundary while not IDLE: set overrun, do not restart; the current pair continues.
  - SETTLE: count down SETTLE cycles, then go to START.
  - START: adc_start=1 for exactly this cycle, then go to WAIT.
    - adc_done in the START cycle is ignored.
  - WAIT: on adc_done, register adc_data into diff_x and go to PUBLISH.
    - adc_done in any other state is ignored.
  - PUBLISH: for one cycle, diff_en=1 and diff_channel = channel of the current phase.
    - Phase I: next cycle adc_ch<=Q_CH, phase=Q, go to SETTLE (or START if SETTLE=0).
    - Phase Q: pair_tick=1 in the same cycle, then go to IDLE.
- Latency:
  - adc_done at cycle t gives diff_en at cycle t+1.
  - Minimum pair length = 2*(SETTLE+3) cycles, assuming done arrives the cycle after WAIT is entered.
- Output holding: diff_x and diff_channel hold their values between strobes.
- run deasserted mid-pair: the pair completes (both I and Q are published), then the FSM stays in IDLE. No new boundary occurs.
- run rising edge: clears overrun and timeout_err.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight conversion result is discarded.

Optional Feature:
- Macro: ADC_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter runs from entry to WAIT.
  - If TIMEOUT cycles elapse without adc_done, the sequencer goes to PUBLISH with diff_x = 10'd512 (midscale) and sets timeout_err.
  - The sequence then continues normally.
- Undefined: WAIT waits indefinitely, timeout_err is tied to 0, and the TIMEOUT parameter is unused.

Test Plan:
- Reset/idle: rst=1 then 0, run=0 for 100 cycles -> no adc_start, no diff_en, adc_ch=3'b110, all flags 0.
- Nominal pair: run=1, SETTLE=4, PERIOD=64, ADC model returns done 3 cycles after start with I=10'h2A0 and Q=10'h120.
  - diff_en with (3'b110, 10'h2A0), then diff_en with (3'b100, 10'h120).
  - pair_tick coincides with the second strobe.
  - Repeats every 64 cycles; overrun stays 0.
- Overrun: PERIOD=8, ADC done latency 10 cycles -> overrun=1 after the first boundary. Every pair still completes in I-then-Q order and is never aborted.
- Spurious done: adc_done pulsed during SETTLE and in the START cycle -> ignored. Only the done in WAIT is captured, one diff_en per phase.
- run drop: deassert run in the cycle after the I diff_en -> Q is still published with pair_tick, then IDLE with busy=0 and no further adc_start.
- Timeout (ADC_TIMEOUT_EN, TIMEOUT=20): ADC never responds -> diff_en with diff_x=10'd512 twenty cycles after each WAIT entry, and timeout_err=1. The next run rising edge clears it.
